// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: observer for the 2-bit light code bus.
// It decodes the code to one-hot lamp drives and tracks how long the current colour has been held.
// It also counts red->green transitions and latches the first protocol violation since the last clear.
module traffic_light_monitor #(
  parameter int unsigned DWELL_W    = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_YELLOW = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         light,
  input  logic               clear_err,
  output logic               red,
  output logic               yellow,
  output logic               green,
  output logic [DWELL_W-1:0] dwell,
  output logic [CNT_W-1:0]   cycles,
  output logic               err,
  output logic [1:0]         err_code
);

  localparam logic [1:0] CodeNone   = 2'b00;
  localparam logic [1:0] CodeRed    = 2'b01;
  localparam logic [1:0] CodeGreen  = 2'b10;
  localparam logic [1:0] CodeYellow = 2'b11;

  localparam logic [1:0] ErrIllegal = 2'd1;
  localparam logic [1:0] ErrOrder   = 2'd2;
  localparam logic [1:0] ErrShort   = 2'd3;

  localparam logic [DWELL_W-1:0] DwellMax  = {DWELL_W{1'b1}};
  localparam logic [DWELL_W-1:0] DwellOne  = DWELL_W'(1);
  localparam logic [DWELL_W-1:0] MinYellow = DWELL_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0]   CycOne    = CNT_W'(1);

  typedef enum logic {StSync, StTrack} state_e;

  state_e             state_q, state_d;
  logic [1:0]         prev_q, prev_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [2:0]         lamp_q, lamp_d;  // {red, yellow, green}

  // Error event raised by the next-state logic on this edge.
  logic               ev;
  logic [1:0]         ev_code;

  // Expected successor of the tracked colour in the legal sequence.
  logic [1:0]         succ;

  // State register: all tracking, counters, error capture and lamp drives.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StSync;
      prev_q     <= CodeNone;
      dwell_q    <= '0;
      cycles_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      lamp_q     <= 3'b000;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      dwell_q    <= dwell_d;
      cycles_q   <= cycles_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      lamp_q     <= lamp_d;
    end
  end

  // Next-state logic: colour tracking, dwell, cycle count and error events.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    dwell_d  = dwell_q;
    cycles_d = cycles_q;
    ev       = 1'b0;
    ev_code  = 2'd0;
    succ     = CodeNone;

    unique case (prev_q)
      CodeRed:    succ = CodeGreen;
      CodeGreen:  succ = CodeYellow;
      CodeYellow: succ = CodeRed;
      default:    succ = CodeNone;
    endcase

    unique case (state_q)
      StSync: begin
        // The first legal code is accepted without a transition check.
        if (light != CodeNone) begin
          state_d = StTrack;
          prev_d  = light;
          dwell_d = DwellOne;
        end
      end
      StTrack: begin
        if (light == CodeNone) begin
          ev      = 1'b1;
          ev_code = ErrIllegal;
          state_d = StSync;
          prev_d  = CodeNone;
          dwell_d = '0;
        end else if (light == prev_q) begin
          if (dwell_q != DwellMax) begin
            dwell_d = dwell_q + DwellOne;
          end
        end else if (light == succ) begin
          prev_d  = light;
          dwell_d = DwellOne;
          if (prev_q == CodeRed) begin
            cycles_d = cycles_q + CycOne;
          end
          // A short yellow is still accepted as a transition.
          if (prev_q == CodeYellow && dwell_q < MinYellow) begin
            ev      = 1'b1;
            ev_code = ErrShort;
          end
        end else begin
          // Out-of-order colour: report and resynchronise on it.
          ev      = 1'b1;
          ev_code = ErrOrder;
          prev_d  = light;
          dwell_d = DwellOne;
        end
      end
      default: begin
        state_d = StSync;
        prev_d  = CodeNone;
        dwell_d = '0;
      end
    endcase
  end

  // Output logic: lamp decode of the next tracked colour and sticky error capture.
  always_comb begin
    lamp_d     = 3'b000;
    err_d      = err_q;
    err_code_d = err_code_q;

    if (state_d == StTrack) begin
      unique case (prev_d)
        CodeRed:    lamp_d = 3'b100;
        CodeYellow: lamp_d = 3'b010;
        CodeGreen:  lamp_d = 3'b001;
        default:    lamp_d = 3'b000;
      endcase
    end

    // A new error beats a simultaneous clear; otherwise the first error is kept.
    if (ev) begin
      err_d = 1'b1;
      if (!err_q || clear_err) begin
        err_code_d = ev_code;
      end
    end else if (clear_err) begin
      err_d      = 1'b0;
      err_code_d = 2'd0;
    end
  end

  assign red      = lamp_q[2];
  assign yellow   = lamp_q[1];
  assign green    = lamp_q[0];
  assign dwell    = dwell_q;
  assign cycles   = cycles_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor with small counters to reach saturation and wrap.
module tb_traffic_light_monitor;

  localparam int DW   = 3;
  localparam int CW   = 2;
  localparam int MINY = 2;
  localparam int DMAX = (1 << DW) - 1;
  localparam int CMOD = 1 << CW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    light = 2'b00;
  logic          clear_err = 1'b0;
  logic          red, yellow, green, err;
  logic [DW-1:0] dwell;
  logic [CW-1:0] cycles;
  logic [1:0]    err_code;

  traffic_light_monitor #(
    .DWELL_W   (DW),
    .CNT_W     (CW),
    .MIN_YELLOW(MINY)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .light    (light),
    .clear_err(clear_err),
    .red      (red),
    .yellow   (yellow),
    .green    (green),
    .dwell    (dwell),
    .cycles   (cycles),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    int lamps;  // {red, yellow, green}
    int dwell;
    int cyc;
    int err;
    int code;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: colour 0 = none tracked, 1 red, 2 green, 3 yellow.
  int m_col = 0, m_run = 0, m_cyc = 0, m_err = 0, m_code = 0;

  function automatic int next_colour(input int c);
    case (c)
      1: return 2;
      2: return 3;
      3: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int lamp_bits(input int c);
    case (c)
      1: return 4;
      3: return 2;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input int l, input int clr, input int rst_n);
    int ev;
    int code;
    ev = 0;
    code = 0;
    if (rst_n == 0) begin
      m_col = 0; m_run = 0; m_cyc = 0; m_err = 0; m_code = 0;
    end else begin
      if (l == 0) begin
        if (m_col != 0) begin ev = 1; code = 1; end
        m_col = 0;
        m_run = 0;
      end else if (m_col == 0) begin
        m_col = l;
        m_run = 1;
      end else if (l == m_col) begin
        m_run = (m_run + 1 > DMAX) ? DMAX : m_run + 1;
      end else if (l == next_colour(m_col)) begin
        if (m_col == 3 && m_run < MINY) begin ev = 1; code = 3; end
        if (m_col == 1) m_cyc = (m_cyc + 1) % CMOD;
        m_col = l;
        m_run = 1;
      end else begin
        ev = 1;
        code = 2;
        m_col = l;
        m_run = 1;
      end
      if (ev != 0) begin
        if (m_err == 0 || clr != 0) m_code = code;
        m_err = 1;
      end else if (clr != 0) begin
        m_err = 0;
        m_code = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one sample, advance one edge and queue the model's view of the outputs.
  task automatic step(input logic [1:0] l, input logic clr, input logic rst_n);
    exp_t e;
    light = l;
    clear_err = clr;
    reset_n = rst_n;
    @(posedge clock);
    model_step(int'(l), int'(clr), int'(rst_n));
    e.lamps = lamp_bits(m_col);
    e.dwell = m_run;
    e.cyc = m_cyc;
    e.err = m_err;
    e.code = m_code;
    sb.push_back(e);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("lamps", {29'd0, red, yellow, green}, e.lamps);
      check("dwell", {{(32 - DW) {1'b0}}, dwell}, e.dwell);
      check("cycles", {{(32 - CW) {1'b0}}, cycles}, e.cyc);
      check("err", {31'd0, err}, e.err);
      check("err_code", {30'd0, err_code}, e.code);
    end
  end

  localparam logic [1:0] R = 2'b01, G = 2'b10, Y = 2'b11, X = 2'b00;

  initial begin
    logic [1:0] last;
    int r;

    // Nominal sequence.
    step(X, 0, 0);
    step(R, 0, 1); step(R, 0, 1); step(R, 0, 1);
    step(G, 0, 1); step(Y, 0, 1); step(Y, 0, 1); step(R, 0, 1);

    // Short yellow.
    step(X, 0, 0);
    step(R, 0, 1); step(G, 0, 1); step(Y, 0, 1); step(R, 0, 1);

    // Out-of-order then illegal code; the first code is kept.
    step(X, 0, 0);
    step(R, 0, 1); step(Y, 0, 1); step(X, 0, 1);

    // Clear colliding with green->red, then a lone clear.
    step(G, 0, 1); step(R, 1, 1); step(R, 1, 1);

    // Dwell saturation and cycle wrap.
    step(X, 0, 0);
    for (int i = 0; i < 10; i++) step(R, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(G, 0, 1); step(Y, 0, 1); step(Y, 0, 1); step(R, 0, 1);
    end

    // Reset mid-green, then re-entry on yellow.
    for (int i = 0; i < 4; i++) step(G, 0, 1);
    step(G, 0, 0);
    step(Y, 0, 1);

    // Randomised traffic biased towards legal sequences.
    last = Y;
    for (int i = 0; i < 600; i++) begin
      logic [1:0] l;
      r = int'($urandom_range(0, 99));
      if (r < 45) l = last;
      else if (r < 82) l = 2'(next_colour(int'(last)));
      else if (r < 92) l = 2'($urandom_range(1, 3));
      else l = X;
      if (l == X) l = (r < 96) ? X : 2'($urandom_range(1, 3));
      step(l, ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) != 0));
      if (l != X) last = l;
    end

    repeat (3) @(negedge clock);
    check("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
